// File: rtl/fifo_udp_pkt_reader.sv
// fifo_udp_pkt_reader: drains full packets from a 1-cycle-latency FIFO into a UDP TX engine; FIFO_PKT_TIMEOUT_EN adds partial-packet flush
module fifo_udp_pkt_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int LVL_WIDTH   = 11,
  parameter int PKT_WORDS   = 256,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 125000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [LVL_WIDTH-1:0]  fifo_rd_water_level,
  output logic                  tx_start_en,
  output logic [15:0]           tx_byte_num,
  input  logic                  tx_req,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic [15:0]           pkt_cnt,
  output logic                  err
);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_SEND = 3'd2, S_WAIT = 3'd3, S_GAP = 3'd4;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [LVL_WIDTH-1:0] PKT_LVL = LVL_WIDTH'(PKT_WORDS);
  logic [2:0]           state;
  logic [LVL_WIDTH-1:0] words_left;
  logic [GW-1:0]        gap_cnt;
  logic                 full_pkt, to_fire, proto_err, left_zero;
  logic [LVL_WIDTH-1:0] start_words;
  assign full_pkt    = fifo_rd_water_level >= PKT_LVL;
  assign start_words = full_pkt ? PKT_LVL : fifo_rd_water_level;
  assign left_zero   = words_left == '0;
  assign fifo_rd_en  = (state == S_SEND) & tx_req & ~left_zero & ~fifo_rd_empty;
  assign tx_start_en = state == S_START;
  assign tx_data     = fifo_rd_data;
  assign proto_err   = (tx_req & left_zero & (state == S_SEND | state == S_WAIT)) |
                       ((state == S_SEND) & ((tx_req & fifo_rd_empty) | tx_done));
`ifdef FIFO_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  assign to_fire = (state == S_IDLE) & ~full_pkt & (fifo_rd_water_level != '0) &
                   (to_cnt == TW'(TIMEOUT_CYC - 1));
  // age a partial packet waiting in IDLE; any other condition restarts the count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_cnt <= '0;
    else to_cnt <= (state != S_IDLE || full_pkt || fifo_rd_water_level == '0 || to_fire) ? '0 : to_cnt + TW'(1);
`else
  logic unused_timeout;
  assign to_fire        = 1'b0;
  assign unused_timeout = TIMEOUT_CYC == 0;
`endif
  // packet sequencing, word accounting, completion count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      words_left  <= '0;
      tx_byte_num <= '0;
      gap_cnt     <= '0;
      pkt_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      err <= err | proto_err;
      case (state)
        S_IDLE: if (full_pkt || to_fire) begin
          words_left  <= start_words;
          tx_byte_num <= 16'(start_words) * 16'(DATA_WIDTH / 8);
          state       <= S_START;
        end
        S_START: state <= S_SEND;
        S_SEND: if (tx_done) begin
          gap_cnt <= '0;
          state   <= S_GAP;
        end else if (fifo_rd_en) begin
          words_left <= words_left - LVL_WIDTH'(1);
          if (words_left == LVL_WIDTH'(1)) state <= S_WAIT;
        end
        S_WAIT: if (tx_done) begin
          pkt_cnt <= pkt_cnt + 16'd1;
          gap_cnt <= '0;
          state   <= S_GAP;
        end
        S_GAP: if (gap_cnt == GW'(GAP_CYC - 1)) state <= S_IDLE;
               else gap_cnt <= gap_cnt + GW'(1);
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_udp_pkt_reader.sv
// tb_fifo_udp_pkt_reader: FIFO/UDP environment with word-order scoreboard for fifo_udp_pkt_reader
module tb_fifo_udp_pkt_reader;
  localparam int DW = 32, LW = 11, PKT = 256, GAP = 16, TO = 100;
  logic clk = 0, rst_n = 0, tx_req = 0, tx_done = 0;
  logic fifo_rd_en, fifo_rd_empty, tx_start_en, err;
  logic [DW-1:0] fifo_rd_data = '0, tx_data;
  logic [LW-1:0] lvl;
  logic [15:0] tx_byte_num, pkt_cnt;
  int wr_ptr = 0, rd_ptr = 0, exp_ptr = 0, exp_pkts = 0, checks = 0, errors = 0, c;
  logic [31:0] mem [4096];
  typedef struct {int add; int cycles; bit exp_start;} row_t;
  row_t rows [3];

  fifo_udp_pkt_reader #(.DATA_WIDTH(DW), .LVL_WIDTH(LW), .PKT_WORDS(PKT), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(lvl), .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
    .pkt_cnt(pkt_cnt), .err(err));

  always #5 clk = ~clk;
  assign lvl = LW'(wr_ptr - rd_ptr);
  assign fifo_rd_empty = wr_ptr == rd_ptr;
  // FIFO model: word index order, data one cycle after the read enable
  always @(posedge clk)
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr & 4095];
      rd_ptr <= rd_ptr + 1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_start(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (tx_start_en) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic send_words(input int n, input int gapmax);
    int k = 0;
    bit pend = 0;
    while (k < n || pend) begin
      @(negedge clk);
      if (pend) begin
        chk("tx_data_word", tx_data, mem[exp_ptr & 4095]);
        exp_ptr++;
        pend = 0;
      end
      tx_req = 0;
      if (k < n && (gapmax == 0 || $urandom_range(gapmax, 0) == 0)) begin
        tx_req = 1;
        #1 chk("rd_en_on_req", fifo_rd_en, 1);
        pend = 1;
        k++;
      end
    end
  endtask

  task automatic done_pulse(input bit complete);
    @(negedge clk) tx_done = 1;
    @(negedge clk) tx_done = 0;
    if (complete) exp_pkts++;
    chk("pkt_cnt_after_done", pkt_cnt, 16'(exp_pkts));
  endtask

  task automatic fill_to(input int n);
    if (wr_ptr - rd_ptr < n) wr_ptr = rd_ptr + n;
  endtask

  task automatic start_full;
    fill_to(PKT);
    wait_start(GAP + 10, c);
    chk("start_seen", c > 0, 1);
    chk("byte_num_full", tx_byte_num, 16'(PKT * DW / 8));
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    rows[0] = '{100, 8, 1'b0};
    rows[1] = '{155, 8, 1'b0};
    rows[2] = '{1, 8, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_start", tx_start_en, 0);
    chk("rst_bytes", tx_byte_num, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    foreach (rows[r]) begin
      wr_ptr += rows[r].add;
      wait_start(rows[r].cycles, c);
      chk("threshold_start", c > 0, rows[r].exp_start);
      if (c > 0) begin
        chk("threshold_bytes", tx_byte_num, 16'(PKT * DW / 8));
        @(negedge clk) chk("start_one_cycle", tx_start_en, 0);
      end
    end
    send_words(PKT, 0);
    chk("no_err_clean_pkt", err, 0);
    chk("pkt_cnt_before_done", pkt_cnt, 0);
    wr_ptr += 300;
    done_pulse(1);
    wait_start(GAP + 10, c);
    chk("gap_respected", c > 0 && c + 1 >= GAP, 1);
    chk("byte_num_pkt2", tx_byte_num, 16'(PKT * DW / 8));
    send_words(PKT, 3);
    chk("no_err_pkt2", err, 0);
    @(negedge clk) tx_req = 1;
    #1 chk("extra_req_no_read", fifo_rd_en, 0);
    @(negedge clk) tx_req = 0;
    chk("extra_req_err", err, 1);
    done_pulse(1);
    chk("err_sticky", err, 1);
    start_full;
    send_words(100, 0);
    @(negedge clk) begin
      tx_req = 1;
      rst_n = 0;
    end
    exp_pkts = 0;
    #1 chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_start", tx_start_en, 0);
    chk("midrst_bytes", tx_byte_num, 0);
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    chk("midrst_err", err, 0);
    @(negedge clk) begin
      tx_req = 0;
      rst_n = 1;
    end
    start_full;
    send_words(PKT, 2);
    done_pulse(1);
    start_full;
    send_words(50, 1);
    done_pulse(0);
    chk("abort_err", err, 1);
    repeat (3) begin
      start_full;
      send_words(PKT, $urandom_range(4, 0));
      done_pulse(1);
    end
    repeat (GAP + 5) @(negedge clk);
    wr_ptr += 10;
    wait_start(TO + 40, c);
`ifdef FIFO_PKT_TIMEOUT_EN
    chk("timeout_start_cycle", c >= TO && c <= TO + 2, 1);
    chk("timeout_bytes", tx_byte_num, 16'd40);
    send_words(10, 0);
    @(negedge clk) tx_req = 1;
    #1 chk("timeout_extra_no_read", fifo_rd_en, 0);
    @(negedge clk) tx_req = 0;
    chk("timeout_all_read", lvl, 0);
`else
    chk("no_timeout_start", c, -1);
    chk("partial_left_in_fifo", lvl, 10);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
